// File: rtl/gridworld_env_if.sv
// Action/result handshake bundle between the DQN agent and the grid-world environment.
// The agent drives the master side and the environment implements the slave side.
interface gridworld_env_if #(
    parameter int unsigned ST_W = 4,
    parameter int unsigned SC_W = 4,
    parameter int unsigned RW   = 8
);
    logic                   ep_start;
    logic                   act_valid;
    logic [1:0]             act;
    logic                   act_ready;
    logic                   res_valid;
    logic                   res_ready;
    logic [ST_W-1:0]        st;
    logic [ST_W-1:0]        st1;
    logic signed [RW-1:0]   reward;
    logic                   blocked;
    logic                   done_goal;
    logic                   truncated;
    logic [SC_W-1:0]        step_cnt;

    modport master (
        output ep_start, act_valid, act, res_ready,
        input  act_ready, res_valid, st, st1, reward, blocked, done_goal, truncated, step_cnt
    );

    modport slave (
        input  ep_start, act_valid, act, res_ready,
        output act_ready, res_valid, st, st1, reward, blocked, done_goal, truncated, step_cnt
    );
endinterface

// File: rtl/gridworld_env.sv
// Parametrised grid-world environment: accepts one action per step, returns next state,
// signed reward and episode-end flags with a one-cycle result latency.
module gridworld_env #(
    parameter int ROWS        = 3,
    parameter int COLS        = 3,
    parameter int START_ST    = 1,
    parameter int GOAL_ST     = 9,
    parameter logic [ROWS*COLS-1:0] OBST_MASK = '0,
    parameter int MAX_STEPS   = 14,
    parameter int RW          = 8,
    parameter int GOAL_REWARD = 10,
    parameter int STEP_REWARD = -1,
    parameter int WALL_REWARD = -2,
    localparam int ST_W       = $clog2(ROWS*COLS+1),
    localparam int SC_W       = $clog2(MAX_STEPS+1)
) (
    input logic            clk,
    input logic            rst,
    gridworld_env_if.slave bus
);

    localparam int N  = ROWS * COLS;
    localparam int NP = 1 << ST_W;

    typedef logic [NP-1:0] mask_t;

    // Per-state edge masks indexed by the 1-based state; built at elaboration.
    function automatic mask_t edge_mask(input int kind);
        mask_t m;
        m = '0;
        for (int s = 1; s <= N; s++) begin
            int r;
            int c;
            r = (s - 1) / COLS;
            c = (s - 1) % COLS;
            case (kind)
                0:       m[ST_W'(s)] = (c == COLS - 1);
                1:       m[ST_W'(s)] = (r == 0);
                2:       m[ST_W'(s)] = (c == 0);
                3:       m[ST_W'(s)] = (r == ROWS - 1);
                default: m[ST_W'(s)] = 1'b0;
            endcase
        end
        return m;
    endfunction

    localparam mask_t RIGHT_M = edge_mask(0);
    localparam mask_t TOP_M   = edge_mask(1);
    localparam mask_t LEFT_M  = edge_mask(2);
    localparam mask_t BOT_M   = edge_mask(3);
    localparam mask_t OBST_PAD = NP'({OBST_MASK, 1'b0});

    localparam logic [ST_W-1:0] ST_ONE  = ST_W'(1);
    localparam logic [ST_W-1:0] COLS_W  = ST_W'(COLS);
    localparam logic [ST_W-1:0] START_W = ST_W'(START_ST);
    localparam logic [ST_W-1:0] GOAL_W  = ST_W'(GOAL_ST);
    localparam logic [SC_W-1:0] SC_ONE  = SC_W'(1);
    localparam logic [SC_W-1:0] LAST_SC = SC_W'(MAX_STEPS - 1);
    localparam logic [RW-1:0]   GOAL_R  = RW'(GOAL_REWARD);
    localparam logic [RW-1:0]   STEP_R  = RW'(STEP_REWARD);
    localparam logic [RW-1:0]   WALL_R  = RW'(WALL_REWARD);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StWaitAct = 2'd1,
        StResult  = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [ST_W-1:0] st_q, st_d;
    logic [ST_W-1:0] st1_q, st1_d;
    logic [SC_W-1:0] step_q, step_d;
    logic [RW-1:0]   reward_q, reward_d;
    logic            res_valid_q, res_valid_d;
    logic            blocked_q, blocked_d;
    logic            goal_q, goal_d;
    logic            trunc_q, trunc_d;

    logic [ST_W-1:0] tgt;
    logic            edge_hit;
    logic            stay;
    logic [ST_W-1:0] move_st;
    logic            move_goal;
    logic            move_trunc;
    logic [RW-1:0]   move_reward;

    // Candidate target may wrap when edge_hit is set; it is discarded in that case.
    always_comb begin
        tgt      = st_q;
        edge_hit = 1'b0;
        unique case (bus.act)
            2'd0: begin edge_hit = RIGHT_M[st_q]; tgt = st_q + ST_ONE; end
            2'd1: begin edge_hit = TOP_M[st_q];   tgt = st_q - COLS_W; end
            2'd2: begin edge_hit = LEFT_M[st_q];  tgt = st_q - ST_ONE; end
            2'd3: begin edge_hit = BOT_M[st_q];   tgt = st_q + COLS_W; end
        endcase
        stay        = edge_hit | OBST_PAD[tgt];
        move_st     = stay ? st_q : tgt;
        move_goal   = (move_st == GOAL_W);
        move_trunc  = ~move_goal & (step_q == LAST_SC);
        move_reward = move_goal ? GOAL_R : (stay ? WALL_R : STEP_R);
    end

    always_comb begin
        state_d     = state_q;
        st_d        = st_q;
        st1_d       = st1_q;
        step_d      = step_q;
        reward_d    = reward_q;
        res_valid_d = res_valid_q;
        blocked_d   = blocked_q;
        goal_d      = goal_q;
        trunc_d     = trunc_q;

        if (bus.ep_start) begin
            state_d     = StWaitAct;
            st_d        = START_W;
            st1_d       = START_W;
            step_d      = '0;
            reward_d    = '0;
            res_valid_d = 1'b0;
            blocked_d   = 1'b0;
            goal_d      = 1'b0;
            trunc_d     = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StWaitAct: begin
                    if (bus.act_valid) begin
                        st1_d       = move_st;
                        reward_d    = move_reward;
                        blocked_d   = stay;
                        goal_d      = move_goal;
                        trunc_d     = move_trunc;
                        res_valid_d = 1'b1;
                        state_d     = StResult;
                    end
                end
                StResult: begin
                    if (bus.res_ready) begin
                        st_d        = st1_q;
                        step_d      = step_q + SC_ONE;
                        res_valid_d = 1'b0;
                        state_d     = (goal_q | trunc_q) ? StIdle : StWaitAct;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            st_q        <= START_W;
            st1_q       <= START_W;
            step_q      <= '0;
            reward_q    <= '0;
            res_valid_q <= 1'b0;
            blocked_q   <= 1'b0;
            goal_q      <= 1'b0;
            trunc_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            st_q        <= st_d;
            st1_q       <= st1_d;
            step_q      <= step_d;
            reward_q    <= reward_d;
            res_valid_q <= res_valid_d;
            blocked_q   <= blocked_d;
            goal_q      <= goal_d;
            trunc_q     <= trunc_d;
        end
    end

    assign bus.act_ready = (state_q == StWaitAct) & ~bus.ep_start;
    assign bus.res_valid = res_valid_q;
    assign bus.st        = st_q;
    assign bus.st1       = st1_q;
    assign bus.reward    = reward_q;
    assign bus.blocked   = blocked_q;
    assign bus.done_goal = goal_q;
    assign bus.truncated = trunc_q;
    assign bus.step_cnt  = step_q;

endmodule

// File: tb/tb_gridworld_env.sv
// Bench for gridworld_env: directed episodes plus random traffic, all checked every cycle
// against a coordinate-based model of the grid world.
module tb_gridworld_env;

    localparam int ROWS      = 3;
    localparam int COLS      = 3;
    localparam int N         = ROWS * COLS;
    localparam int START     = 1;
    localparam int GOAL      = 9;
    localparam int MAX_STEPS = 14;
    localparam int RW        = 8;
    localparam int ST_W      = $clog2(N + 1);
    localparam int SC_W      = $clog2(MAX_STEPS + 1);
    localparam logic [N-1:0] OBST = 9'b0_0001_0000;  // state 5 is an obstacle

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    gridworld_env_if #(.ST_W(ST_W), .SC_W(SC_W), .RW(RW)) bus ();

    gridworld_env #(.OBST_MASK(OBST)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input int act_v, input int exp_v);
        tests++;
        if (act_v != exp_v) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act_v, exp_v, $time);
        end
    endtask

    // Model: plain row/column arithmetic on the grid.
    function automatic int move_to(input int s, input int a);
        logic [N-1:0] om;
        int r, c, nr, nc;
        om = OBST;
        r  = (s - 1) / COLS;
        c  = (s - 1) % COLS;
        nr = r;
        nc = c;
        case (a)
            0:       nc = c + 1;
            1:       nr = r - 1;
            2:       nc = c - 1;
            default: nr = r + 1;
        endcase
        if (nr < 0 || nr >= ROWS || nc < 0 || nc >= COLS) return s;
        if (om[nr*COLS+nc]) return s;
        return nr * COLS + nc + 1;
    endfunction

    // phase: 0 no episode running, 1 expecting an action, 2 holding a result
    int m_phase = 0, m_st = START, m_st1 = START, m_step = 0, m_rv = 0;
    int m_rew = 0, m_blk = 0, m_goal = 0, m_trunc = 0, m_t;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_phase = 0; m_st = START; m_st1 = START; m_step = 0; m_rv = 0;
            m_rew = 0; m_blk = 0; m_goal = 0; m_trunc = 0;
        end else if (bus.ep_start) begin
            m_phase = 1; m_st = START; m_st1 = START; m_step = 0; m_rv = 0;
            m_blk = 0; m_goal = 0; m_trunc = 0;
        end else if (m_phase == 1 && bus.act_valid) begin
            m_t     = move_to(m_st, int'(bus.act));
            m_st1   = m_t;
            m_blk   = (m_t == m_st) ? 1 : 0;
            m_goal  = (m_t == GOAL) ? 1 : 0;
            m_trunc = (m_goal == 0 && m_step + 1 == MAX_STEPS) ? 1 : 0;
            m_rew   = m_goal ? 10 : (m_blk ? -2 : -1);
            m_rv    = 1;
            m_phase = 2;
        end else if (m_phase == 2 && bus.res_ready) begin
            m_st    = m_st1;
            m_step  = m_step + 1;
            m_rv    = 0;
            m_phase = (m_goal || m_trunc) ? 0 : 1;
        end
    end

    always @(negedge clk) begin
        check("st", int'(bus.st), m_st);
        check("step_cnt", int'(bus.step_cnt), m_step);
        check("res_valid", int'(bus.res_valid), m_rv);
        check("act_ready", int'(bus.act_ready), (m_phase == 1 && !bus.ep_start) ? 1 : 0);
        if (m_rv != 0) begin
            check("st1", int'(bus.st1), m_st1);
            check("reward", int'(bus.reward), m_rew);
            check("blocked", int'(bus.blocked), m_blk);
            check("done_goal", int'(bus.done_goal), m_goal);
            check("truncated", int'(bus.truncated), m_trunc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        bus.ep_start = 1'b1;
        tick();
        bus.ep_start = 1'b0;
    endtask

    task automatic do_step(input int a, input int hold, output int s1, output int rw,
                           output int bl, output int dg, output int tr);
        int n;
        n = 0;
        while (!bus.act_ready && n < 20) begin
            tick();
            n++;
        end
        check("act_ready_wait", int'(bus.act_ready), 1);
        bus.act_valid = 1'b1;
        bus.act       = 2'(a);
        tick();
        bus.act_valid = 1'b0;
        check("result_latency", int'(bus.res_valid), 1);
        s1 = int'(bus.st1);
        rw = int'(bus.reward);
        bl = int'(bus.blocked);
        dg = int'(bus.done_goal);
        tr = int'(bus.truncated);
        repeat (hold) tick();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    initial begin
        int s1, rw, bl, dg, tr;
        int exp_s[4];
        int exp_r[4];
        int acts[4];
        exp_s = '{2, 3, 6, 9};
        exp_r = '{-1, -1, -1, 10};
        acts  = '{0, 0, 3, 3};

        bus.ep_start = 1'b0; bus.act_valid = 1'b0; bus.act = 2'd0; bus.res_ready = 1'b0;
        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_st", int'(bus.st), 1);
        check("rst_st1", int'(bus.st1), 1);
        check("rst_step", int'(bus.step_cnt), 0);
        check("rst_res_valid", int'(bus.res_valid), 0);
        check("rst_act_ready", int'(bus.act_ready), 0);
        check("rst_reward", int'(bus.reward), 0);

        // Shortest path to the goal.
        pulse_start();
        for (int i = 0; i < 4; i++) begin
            do_step(acts[i], 0, s1, rw, bl, dg, tr);
            check("path_st1", s1, exp_s[i]);
            check("path_reward", rw, exp_r[i]);
            check("path_goal", dg, (i == 3) ? 1 : 0);
        end
        check("goal_step_cnt", int'(bus.step_cnt), 4);
        check("goal_idle_ready", int'(bus.act_ready), 0);

        // Edge blocks from the top-left corner.
        pulse_start();
        do_step(1, 0, s1, rw, bl, dg, tr);
        check("up_st1", s1, 1); check("up_blk", bl, 1); check("up_rew", rw, -2);
        do_step(2, 0, s1, rw, bl, dg, tr);
        check("left_st1", s1, 1); check("left_blk", bl, 1); check("left_rew", rw, -2);

        // Obstacle at state 5.
        pulse_start();
        do_step(0, 0, s1, rw, bl, dg, tr);
        do_step(3, 0, s1, rw, bl, dg, tr);
        check("obst_down_st1", s1, 2); check("obst_down_blk", bl, 1);
        check("obst_down_rew", rw, -2);
        do_step(2, 0, s1, rw, bl, dg, tr);
        do_step(3, 0, s1, rw, bl, dg, tr);
        do_step(0, 0, s1, rw, bl, dg, tr);
        check("obst_right_st1", s1, 4); check("obst_right_blk", bl, 1);

        // Step limit.
        pulse_start();
        for (int i = 0; i < MAX_STEPS; i++) begin
            do_step(1, 0, s1, rw, bl, dg, tr);
            check("limit_trunc", tr, (i == MAX_STEPS - 1) ? 1 : 0);
        end
        check("limit_goal", dg, 0);
        check("limit_rew", rw, -2);
        check("limit_step_cnt", int'(bus.step_cnt), 14);
        check("limit_idle_ready", int'(bus.act_ready), 0);

        // Backpressure.
        pulse_start();
        bus.act_valid = 1'b1; bus.act = 2'd0;
        tick();
        bus.act_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("bp_st1", int'(bus.st1), 2);
            check("bp_st", int'(bus.st), 1);
            check("bp_ready", int'(bus.act_ready), 0);
            tick();
        end
        bus.res_ready = 1'b1;
        check("bp_st_before", int'(bus.st), 1);
        tick();
        bus.res_ready = 1'b0;
        check("bp_st_after", int'(bus.st), 2);

        // Abort with a pending result.
        pulse_start();
        do_step(0, 0, s1, rw, bl, dg, tr);
        bus.act_valid = 1'b1; bus.act = 2'd0;
        tick();
        bus.act_valid = 1'b0;
        check("abort_pending", int'(bus.st1), 3);
        bus.ep_start = 1'b1; bus.res_ready = 1'b1;
        tick();
        bus.ep_start = 1'b0; bus.res_ready = 1'b0;
        check("abort_res_valid", int'(bus.res_valid), 0);
        check("abort_st", int'(bus.st), 1);
        check("abort_step", int'(bus.step_cnt), 0);
        bus.ep_start = 1'b1; bus.act_valid = 1'b1; bus.act = 2'd3;
        #1 check("start_vs_act_ready", int'(bus.act_ready), 0);
        tick();
        bus.ep_start = 1'b0; bus.act_valid = 1'b0;
        check("start_vs_act_result", int'(bus.res_valid), 0);

        // Asynchronous reset mid-episode.
        do_step(0, 0, s1, rw, bl, dg, tr);
        bus.act_valid = 1'b1; bus.act = 2'd3;
        tick();
        bus.act_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("arst_st", int'(bus.st), 1);
        check("arst_st1", int'(bus.st1), 1);
        check("arst_res_valid", int'(bus.res_valid), 0);
        check("arst_step", int'(bus.step_cnt), 0);
        check("arst_reward", int'(bus.reward), 0);
        check("arst_blocked", int'(bus.blocked), 0);
        tick();
        rst = 1'b0;
        check("arst_idle_ready", int'(bus.act_ready), 0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bus.ep_start  = (i == 0) || ($urandom_range(0, 24) == 0);
            bus.act_valid = 1'($urandom_range(0, 1));
            bus.act       = 2'($urandom_range(0, 3));
            bus.res_ready = 1'($urandom_range(0, 1));
            tick();
        end
        bus.ep_start = 1'b0; bus.act_valid = 1'b0; bus.res_ready = 1'b0;
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
